// File: rtl/obuf_fifo.sv
// Registered first-word-fall-through output buffer with a valid/ready handshake on both sides,
// occupancy reporting and a synchronous flush. Every output is decoded from registered state only.
module obuf_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level
);

  localparam int            PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push;
  logic             pop;

  // in_ready looks at count alone, so a full buffer refuses a word even in a cycle that pops.
  assign in_ready  = (count != FULL_L);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign level     = count;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; stale entries are never visible because out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= in_data;
  end

endmodule

// File: doc/obuf_fifo.md
# obuf_fifo

Parametrised registered output buffer, the successor to our 8-bit combinational output buffer. It takes words from internal logic over a valid/ready handshake and stores up to DEPTH of them in a first-word-fall-through queue. It presents them to the output stage (LED/pin drivers or a downstream consumer) from registers only. It decouples producer and consumer timing and adds occupancy reporting and a synchronous flush, neither of which the plain buffer has.

## Interface
- WIDTH, 8, data word width in bits (>= 1).
- DEPTH, 4, queue depth in words; power of two, >= 2.
- LW, $clog2(DEPTH+1), width of the level output; derived, not overridden.

- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- flush  in  1  synchronous queue clear, active-high.
- in_data  in  WIDTH  producer word.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  buffer can accept a word this cycle.
- out_data  out  WIDTH  head-of-queue word; 0 when out_valid = 0.
- out_valid  out  1  head word present.
- out_ready  in  1  consumer takes the head word this cycle.
- level  out  LW  number of stored words, 0..DEPTH.

## Operation
- Storage is a DEPTH-entry register array with wr_ptr and rd_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH, plus a count register of LW bits.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It derives from registered state only and does not depend on out_ready, so a full buffer does not accept a word even when a pop occurs in the same cycle.
- out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, else all zeros.
- On push: mem[wr_ptr] <= in_data and wr_ptr <= wr_ptr + 1.
- On pop: rd_ptr <= rd_ptr + 1.
- Count update: +1 on push only; -1 on pop only; unchanged when both or neither occur.
- level = count.
- Priority order is rst, then flush, then push/pop.
- rst: wr_ptr, rd_ptr and count go to 0. Memory contents are don't-care because out_data is masked while empty.
- flush: same clearing effect as rst. A push or pop in the flush cycle is discarded, and the flushed words are lost.
- A mid-stream rst or flush behaves identically regardless of occupancy. The next push after it lands at entry 0.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Ordering stays strictly FIFO across any number of wraps.
- Words are never dropped or duplicated outside flush/rst.

## Timing
- Reset values, in the cycle after rst is sampled high: in_ready = 1, out_valid = 0, out_data = 0, level = 0.
- Latency: a word pushed at edge N is visible on out_data, with out_valid = 1, from edge N onward when the queue was empty. One cycle of in-to-out latency, no bypass path.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Backpressure: while out_valid = 1 and out_ready = 0, out_data and out_valid are stable until a pop or flush/rst.
- in_ready falls in the cycle after the push that makes count = DEPTH. It rises in the cycle after the first pop from full.
- No combinational path from any input to any output. All outputs are functions of registered state.

## Test plan
- Reset: hold rst for 2 cycles with in_valid = 1 and in_data = 8'hFF. Required afterwards: level = 0, out_valid = 0, out_data = 0, in_ready = 1, and no word stored.
- Fill/full (WIDTH 8, DEPTH 4), out_ready = 0:
  - Push 0x11, 0x22, 0x33, 0x44: level reaches 4, in_ready = 0, out_data = 0x11.
  - A fifth word 0x55 offered while full is not accepted and level stays 4.
- Drain order: from full, hold out_ready = 1. Required: out_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then out_valid = 0, out_data = 0, level = 0.
- Simultaneous push/pop with wrap: stream 10 words 0x01..0x0A with out_ready = 1 and in_valid = 1 continuously. Required: level stays 1, output sequence is 0x01..0x0A each one cycle after its push, and the pointers wrap twice with no loss.
- Flush priority: with level = 3, assert flush together with in_valid = 1 (0x77) and out_ready = 1. Required next cycle: level = 0, out_valid = 0, and 0x77 not stored. A following push of 0x88 appears alone on out_data.
- Backpressure stability: level = 2 with head 0xA5 and out_ready = 0 for 5 cycles. Required: out_data = 0xA5 and out_valid = 1 stable on every cycle, then 0xA5 is popped on the first out_ready = 1 cycle.
